// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and port ids.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dm_arb_pick.sv
// Grant selection between the two requesters; a lone requester always wins,
// on contention the port that was not granted last wins.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = req0 & (~req1 | (last == PORT1));
    gnt1 = req1 & ~gnt0;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-ported, asynchronous-read data memory.
// Define DM_ARB_RR_EN for round-robin on contention; default is fixed priority to port 0.
//
// Handshake: a requester holds req and its command stable until gnt is seen high
// (combinational, IDLE only); the access happens the next cycle and a one-cycle
// rvalid (with err) is returned the cycle after that, for reads and writes alike.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MEM_WORDS = 3072,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  state_t              state, state_nxt;
  logic                cmd_we;
  logic                cmd_id;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [31:0]         cmd_wdata;
  logic                cmd_err;
  logic [ADDR_W-1:0]   word_idx;
  logic                pick0, pick1;
  logic                last_id;

`ifdef DM_ARB_RR_EN
  // prio names the port that wins the next contended grant.
  logic prio;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= PORT0;
    end else if (gnt0 || gnt1) begin
      prio <= gnt0 ? PORT1 : PORT0;
    end
  end

  assign last_id = ~prio;
`else
  assign last_id = PORT1;
`endif

  dm_arb_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last_id),
    .gnt0 (pick0),
    .gnt1 (pick1)
  );

  assign word_idx  = cmd_addr >> 2;
  assign cmd_err   = (cmd_addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(MEM_WORDS));
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are gated with reset so an aborted access neither writes nor responds.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_we    = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt0 = pick0 & ~reset;
        gnt1 = pick1 & ~reset;
        if (pick0 || pick1) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_we    = cmd_we & ~cmd_err & ~reset;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rvalid0   = ~reset & (cmd_id == PORT0);
        rvalid1   = ~reset & (cmd_id == PORT1);
        err0      = rvalid0 & cmd_err;
        err1      = rvalid1 & cmd_err;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_id    <= PORT0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (gnt0 || gnt1) begin
      cmd_id    <= gnt1 ? PORT1 : PORT0;
      cmd_we    <= gnt1 ? we1 : we0;
      cmd_addr  <= gnt1 ? addr1 : addr0;
      cmd_wdata <= gnt1 ? wdata1 : wdata0;
    end
  end

  // Errored accesses return zero data; good writes leave rdata untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (state == ST_ACCESS) begin
      if (cmd_err) begin
        rdata <= '0;
      end else if (!cmd_we) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: vector table, contention, reset abort and withdrawal.
module tb_dm_arbiter;
  localparam int MEM_WORDS = 3072;
  localparam int ADDR_W    = 32;
  localparam int W         = 35;
  localparam int NV        = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [31:0]       wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
  logic [31:0]       rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        dbg_state;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs [NV];

  dm_arbiter #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign mem_rdata = (int'(mem_addr >> 2) < MEM_WORDS) ? mem[int'(mem_addr >> 2)] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && int'(mem_addr >> 2) < MEM_WORDS) mem[int'(mem_addr >> 2)] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: {check_rdata, port, err, rdata}
  task automatic push_exp(input logic port, input logic we, input logic [31:0] addr,
                          input logic exp_err);
    logic [31:0] rd;
    rd = 32'h0;
    if (!exp_err) begin
      if (we) ref_mem[addr >> 2] = (port ? wdata1 : wdata0);
      else    rd = ref_mem[addr >> 2];
    end
    exp_q.push_back({exp_err | ~we, port, exp_err, rd});
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rvalid0 && rvalid1) chk("rvalid_both", 32'd1, 32'd0);
    if (rvalid0 || rvalid1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", {31'd0, rvalid1}, {31'd0, e[33]});
        chk("resp_err", {31'd0, rvalid1 ? err1 : err0}, {31'd0, e[32]});
        if (e[34]) chk("resp_rdata", rdata, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!(gnt0 || gnt1) && n < 16) begin
      @(negedge clk);
      n++;
    end
    ok = gnt0 || gnt1;
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err);
    bit ok;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    wait_gnt(ok);
    chk("gnt0", {31'd0, gnt0}, {31'd0, ~port});
    chk("gnt1", {31'd0, gnt1}, {31'd0, port});
    if (ok) push_exp(port, we, addr, exp_err);
    @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("mem_we_access", {31'd0, mem_we}, {31'd0, we & ~exp_err});
    chk("gnt_busy", {31'd0, gnt0 | gnt1}, 32'd0);
    if (we && !exp_err) begin
      chk("mem_addr", mem_addr, addr);
      chk("mem_wdata", mem_wdata, wdata);
    end
    @(negedge clk);
    chk("rvalid_t2", {31'd0, port ? rvalid1 : rvalid0}, 32'd1);
    chk("mem_we_resp", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    logic exp_port;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    vecs[0] = '{1'b0, 1'b0, 32'h10,   32'h0,         1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h20,   32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h20,   32'h0,         1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h10,   32'h0,         1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h3,    32'h0,         1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h3000, 32'h0,         1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h2FFC, 32'hCAFE_F00D, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h2FFC, 32'h0,         1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'h3000, 32'hBAD0_0001, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 32'h1,    32'hBAD0_0002, 1'b1};
    for (int i = 10; i < NV; i++) begin
      vecs[i].port    = 1'($urandom_range(0, 1));
      vecs[i].we      = 1'($urandom_range(0, 1));
      vecs[i].addr    = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
      vecs[i].wdata   = $urandom;
      vecs[i].exp_err = 1'b0;
    end

    do_reset();
    @(negedge clk);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst_err", {30'd0, err1, err0}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++)
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err);

    // contention: both ports held for four transactions
    do_reset();
    we0 = 1'b0; addr0 = 32'h40; we1 = 1'b0; addr1 = 32'h80;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok);
`ifdef DM_ARB_RR_EN
      exp_port = 1'(k % 2);
`else
      exp_port = 1'b0;
`endif
      chk("contend_gnt1", {31'd0, gnt1}, {31'd0, exp_port});
      chk("contend_gnt0", {31'd0, gnt0}, {31'd0, ~exp_port});
      if (ok) push_exp(gnt1, 1'b0, gnt1 ? 32'h80 : 32'h40, 1'b0);
    end
    @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset during the access cycle of a write
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hFFFF_0000;
    wait_gnt(ok);
    chk("abort_gnt1", {31'd0, gnt1}, 32'd1);
    @(posedge clk);
    #1 req1 = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    chk("abort_mem", mem[8], ref_mem[8]);
    @(posedge clk);
    #1;
    we0 = 1'b0; addr0 = 32'h10; we1 = 1'b0; addr1 = 32'h10;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(ok);
    chk("post_abort_gnt0", {31'd0, gnt0}, 32'd1);
    if (ok) push_exp(gnt1, 1'b0, 32'h10, 1'b0);
    @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // withdrawal of port 1 while port 0 is busy
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h44;
    wait_gnt(ok);
    chk("wd_gnt0", {31'd0, gnt0}, 32'd1);
    if (ok) push_exp(1'b0, 1'b0, 32'h44, 1'b0);
    @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h48; wdata1 = 32'h5555_AAAA;
    @(negedge clk);
    chk("wd_gnt1_access", {31'd0, gnt1}, 32'd0);
    @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    chk("wd_gnt1_resp", {31'd0, gnt1}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("wd_idle_gnt1", {31'd0, gnt1}, 32'd0);
      chk("wd_idle_mem_we", {31'd0, mem_we}, 32'd0);
    end
    chk("wd_mem", mem[18], ref_mem[18]);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 3072, number of 32-bit words in the shared data memory.
REQ-002 SHALL have parameter ADDR_W, default 32, requester byte-address width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  access request per requester (0 = CPU MEM stage, 1 = DMA/debug).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  byte address.
REQ-008 SHALL have ports wdata0/wdata1  input  32  write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  request accepted this cycle.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  one-cycle response pulse.
REQ-011 SHALL have ports err0/err1  output  1  response is an error; valid only with rvalid.
REQ-012 SHALL have port rdata  output  32  read data, shared; valid with rvalid0 or rvalid1.
REQ-013 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  32, mem_we  output  1, mem_rdata  input  32 (asynchronous-read memory).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-015 IDLE: if any req, SHALL assert exactly one gnt combinationally, latch the winner's we/addr/wdata and port id at the clock edge, and go to ACCESS; otherwise stay in IDLE.
REQ-016 gnt0/gnt1 SHALL be 0 in every state except IDLE.
REQ-017 ACCESS: SHALL drive mem_addr/mem_wdata from latched values and assert mem_we for exactly this one cycle if the request is a valid write; SHALL capture mem_rdata into rdata at the end of the cycle for reads; next state RESP.
REQ-018 RESP: SHALL assert rvalid of the latched port for one cycle, also for writes (write ack), then go to IDLE.
REQ-019 Latency SHALL be: gnt at cycle T, mem access at T+1, rvalid at T+2; next grant possible at T+3.
REQ-020 A request with addr[1:0] != 0 or (addr>>2) >= MEM_WORDS SHALL be granted, SHALL NOT assert mem_we, and SHALL respond with err=1 and rdata=0 at T+2.
REQ-021 mem_we SHALL be 0 outside ACCESS; mem_addr/mem_wdata SHALL hold their last latched values outside ACCESS.
REQ-022 A requester SHALL hold req and command stable until gnt; deasserting req before gnt withdraws the request without side effects.
REQ-023 rdata SHALL hold its value until the next read capture.

Reset
REQ-024 On reset, the FSM SHALL go to IDLE, the priority pointer to port 0, and rvalid0/1, err0/1 and mem_we to 0, with rdata and the latched command cleared to 0.
REQ-025 Reset in ACCESS or RESP SHALL abort the transaction: no rvalid is issued and mem_we is 0 from the reset cycle on.

Configuration
REQ-026 Macro DM_ARB_RR_EN defined: simultaneous req0 and req1 in IDLE SHALL be granted round-robin, to the port not granted last; a single requester always wins.
REQ-027 Macro DM_ARB_RR_EN undefined: port 0 SHALL have fixed priority; the pointer register SHALL not exist.

Structure
REQ-028 The FSM state encoding and the port-id constants SHALL live in shared package dm_arb_pkg.
REQ-029 Grant selection SHALL be the sub-module dm_arb_pick (inputs req0, req1, last; outputs gnt0, gnt1); everything else is in dm_arbiter.

Verification
REQ-030 Single read: req0=1, we0=0, addr0=0x10, mem word 4 = 0xDEADBEEF -> gnt0 at T, rvalid0=1 and rdata=0xDEADBEEF at T+2, err0=0.
REQ-031 Single write: req1=1, we1=1, addr1=0x20, wdata1=0x12345678 -> mem_we=1 with mem_addr=0x20 at T+1 only, rvalid1 at T+2.
REQ-032 Contention: req0 and req1 held high for 4 transactions -> with DM_ARB_RR_EN grants go 0,1,0,1; without it grants go 0,0,0,0.
REQ-033 Error: addr0=0x3 -> err0=1 with rvalid0; addr0=4*MEM_WORDS -> err0=1; in both cases mem_we stays 0.
REQ-034 Reset mid-op: reset asserted in ACCESS of a write -> mem_we=0 in that cycle, no rvalid, FSM in IDLE, next contended grant goes to port 0.
REQ-035 Withdrawal: req1 raised then dropped while a port 0 transaction is busy -> no gnt1 and no rvalid1 issued.
